// File: rtl/sequence_detector.sv
// sequence_detector: serial bit-stream pattern spotter.
// One bit of In is consumed on every rising clk edge. Out pulses (registered)
// for one cycle when the most recent PATTERN_LEN bits equal PATTERN. The
// first-received bit sits at the MSB of PATTERN.
// OVERLAP=1 lets matches share bits; OVERLAP=0 restarts from an empty history
// after each match.
// Optional build macro SEQ_DET_COUNT_EN adds an 8-bit saturating match_count
// output. Out behaves the same in both builds.
module sequence_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1001,
  parameter bit                     OVERLAP     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       In,
`ifdef SEQ_DET_COUNT_EN
  output logic [7:0] match_count,
`endif
  output logic       Out
);

  localparam int HIST_W = PATTERN_LEN - 1;
  localparam int FILL_W = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN - 1);

  // The fill counter stops once the history holds a full window of bits.
  function automatic logic [FILL_W-1:0] sat_fill(input logic [FILL_W-1:0] f);
    return (f == FILL_FULL) ? f : f + 1'b1;
  endfunction

  logic [HIST_W-1:0]      hist_q, hist_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic                   out_q, out_d;
  logic [PATTERN_LEN-1:0] candidate;
  logic                   match;

  // Next-state: build the candidate window. Bits that arrive before the
  // history is fully valid must never match, even if the zero-filled history
  // happens to equal the pattern.
  always_comb begin
    candidate = {hist_q, In};
    match     = (fill_q == FILL_FULL) && (candidate == PATTERN);
    out_d     = match;
    hist_d    = candidate[HIST_W-1:0];
    fill_d    = sat_fill(fill_q);
    if (match && !OVERLAP) begin
      hist_d = '0;
      fill_d = '0;
    end
  end

  // Detector state registers. Reset clears them immediately, without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
    end
  end

  assign Out = out_q;

`ifdef SEQ_DET_COUNT_EN
  // The match counter sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] count_q, count_d;

  // Next count: advance on every edge where the match condition holds.
  always_comb begin
    count_d = count_q;
    if (match) count_d = sat_inc8(count_q);
  end

  // Match counter register. Only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= 8'd0;
    else     count_q <= count_d;
  end

  assign match_count = count_q;
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector. Five configurations share clk, rst and In.
// Expected values come from a stream-history model and from directed constants.
module tb_sequence_detector;

  localparam int NCFG = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_bit = 1'b0;
  logic out_w [NCFG];
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] cnt_w [NCFG];
`endif

  always #5 clk = ~clk;

  sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b1)) u_c0 (
    .clk(clk), .rst(rst), .In(in_bit),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt_w[0]),
`endif
    .Out(out_w[0]));
  sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1001), .OVERLAP(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .In(in_bit),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt_w[1]),
`endif
    .Out(out_w[1]));
  sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b0001), .OVERLAP(1'b1)) u_c2 (
    .clk(clk), .rst(rst), .In(in_bit),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt_w[2]),
`endif
    .Out(out_w[2]));
  sequence_detector #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1)) u_c3 (
    .clk(clk), .rst(rst), .In(in_bit),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt_w[3]),
`endif
    .Out(out_w[3]));
  sequence_detector #(.PATTERN_LEN(3), .PATTERN(3'b101), .OVERLAP(1'b0)) u_c4 (
    .clk(clk), .rst(rst), .In(in_bit),
`ifdef SEQ_DET_COUNT_EN
    .match_count(cnt_w[4]),
`endif
    .Out(out_w[4]));

  // Configuration table mirrored from the instances above.
  int          cfg_len [NCFG];
  logic [31:0] cfg_pat [NCFG];
  bit          cfg_ovl [NCFG];

  // Model: every bit since reset is kept. Per configuration, the model also
  // keeps the index where the current detection window may begin.
  bit stream_q[$];
  int start_idx [NCFG];
  bit exp_out   [NCFG];
  int exp_cnt   [NCFG];

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    stream_q.delete();
    for (int c = 0; c < NCFG; c++) begin
      start_idx[c] = 0;
      exp_out[c]   = 1'b0;
      exp_cnt[c]   = 0;
    end
  endtask

  task automatic model_edge(input bit b);
    int n;
    bit m;
    stream_q.push_back(b);
    n = stream_q.size();
    for (int c = 0; c < NCFG; c++) begin
      m = 1'b0;
      if (n - start_idx[c] >= cfg_len[c]) begin
        m = 1'b1;
        for (int k = 0; k < cfg_len[c]; k++)
          if (stream_q[n - cfg_len[c] + k] != cfg_pat[c][cfg_len[c] - 1 - k]) m = 1'b0;
      end
      exp_out[c] = m;
      if (m && exp_cnt[c] < 255) exp_cnt[c]++;
      if (m && !cfg_ovl[c]) start_idx[c] = n;
    end
  endtask

  // Drive one bit in the low phase, then return 1 time unit after the sampling edge.
  task automatic step(input bit b);
    @(negedge clk);
    #2;
    in_bit = b;
    @(posedge clk);
    model_edge(b);
    #1;
  endtask

  // Reset that spans one rising edge. It is released in the high phase, so
  // the next edge that samples In is the one driven by step().
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    in_bit = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    for (int e = 0; e < 3; e++) begin
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== 1'b0) begin
          errors++;
          $display("FAIL reset_out cfg%0d pass%0d Out got %b want 0", c, e, out_w[c]);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_w[c] !== 8'd0) begin
          errors++;
          $display("FAIL reset_cnt cfg%0d pass%0d count got %0d want 0", c, e, cnt_w[c]);
        end
`endif
      end
      in_bit = ~in_bit;
      @(posedge clk);
      #1;
    end
    #2;
    rst = 1'b0;
  endtask

  task automatic test_default();
    logic [11:0] seq;
    seq = 12'b0001_0011_0100;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(seq[11 - i]);
      checks++;
      if (out_w[0] !== (i == 6)) begin
        errors++;
        $display("FAIL default_dir edge%0d Out got %b want %b", i + 1, out_w[0], (i == 6));
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL default_model cfg%0d edge%0d Out got %b want %b", c, i + 1, out_w[c], exp_out[c]);
        end
      end
    end
`ifdef SEQ_DET_COUNT_EN
    checks++;
    if (cnt_w[0] !== 8'd1) begin
      errors++;
      $display("FAIL default_cnt count got %0d want 1", cnt_w[0]);
    end
`endif
  endtask

  task automatic test_overlap();
    logic [9:0] seq;
    seq = 10'b1001001001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(seq[9 - i]);
      checks++;
      if (out_w[0] !== (i == 3 || i == 6 || i == 9)) begin
        errors++;
        $display("FAIL overlap_on edge%0d Out got %b want %b", i + 1, out_w[0], (i == 3 || i == 6 || i == 9));
      end
      checks++;
      if (out_w[1] !== (i == 3 || i == 9)) begin
        errors++;
        $display("FAIL overlap_off edge%0d Out got %b want %b", i + 1, out_w[1], (i == 3 || i == 9));
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL overlap_model cfg%0d edge%0d Out got %b want %b", c, i + 1, out_w[c], exp_out[c]);
        end
      end
`ifdef SEQ_DET_COUNT_EN
      if (i == 6) begin
        checks++;
        if (cnt_w[0] !== 8'd2 || cnt_w[1] !== 8'd1) begin
          errors++;
          $display("FAIL overlap_cnt counts got %0d/%0d want 2/1", cnt_w[0], cnt_w[1]);
        end
      end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] seq;
    seq = 4'b1001;
    do_reset();
    for (int i = 0; i < 4; i++) step(seq[3 - i]);
    checks++;
    if (out_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre Out got %b want 1", out_w[0]);
    end
    // Assert reset between edges while Out is high; it must clear at once.
    for (int r = 0; r < 2; r++) begin
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_async r%0d cfg%0d Out got %b want 0", r, c, out_w[c]);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_w[c] !== 8'd0) begin
          errors++;
          $display("FAIL midrst_cnt r%0d cfg%0d count got %0d want 0", r, c, cnt_w[c]);
        end
`endif
      end
      rst = 1'b0;
      if (r == 0) for (int i = 0; i < 3; i++) step(seq[3 - i]);
    end
    for (int i = 0; i < 4; i++) begin
      step(seq[3 - i]);
      checks++;
      if (out_w[0] !== (i == 3)) begin
        errors++;
        $display("FAIL midrst_post edge%0d Out got %b want %b", i + 1, out_w[0], (i == 3));
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL midrst_model cfg%0d edge%0d Out got %b want %b", c, i + 1, out_w[c], exp_out[c]);
        end
      end
    end
  endtask

  task automatic test_fill_guard();
    logic [4:0] seq;
    seq = 5'b10001;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(seq[4 - i]);
      checks++;
      if (out_w[2] !== (i == 4)) begin
        errors++;
        $display("FAIL fill_guard edge%0d Out got %b want %b", i + 1, out_w[2], (i == 4));
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL fill_model cfg%0d edge%0d Out got %b want %b", c, i + 1, out_w[c], exp_out[c]);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 1)));
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL random_out cfg%0d step%0d Out got %b want %b", c, i, out_w[c], exp_out[c]);
        end
`ifdef SEQ_DET_COUNT_EN
        checks++;
        if (cnt_w[c] !== 8'(exp_cnt[c])) begin
          errors++;
          $display("FAIL random_cnt cfg%0d step%0d count got %0d want %0d", c, i, cnt_w[c], exp_cnt[c]);
        end
`endif
      end
      if ($urandom_range(0, 63) == 0) do_reset();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step(1'b1);
      checks++;
      if (out_w[3] !== (i >= 3)) begin
        errors++;
        $display("FAIL sat_out edge%0d Out got %b want %b", i + 1, out_w[3], (i >= 3));
      end
      for (int c = 0; c < NCFG; c++) begin
        checks++;
        if (out_w[c] !== exp_out[c]) begin
          errors++;
          $display("FAIL sat_model cfg%0d edge%0d Out got %b want %b", c, i + 1, out_w[c], exp_out[c]);
        end
      end
    end
`ifdef SEQ_DET_COUNT_EN
    checks++;
    if (cnt_w[3] !== 8'd255) begin
      errors++;
      $display("FAIL sat_cnt count got %0d want 255", cnt_w[3]);
    end
`endif
  endtask

  initial begin
    cfg_len[0] = 4; cfg_pat[0] = 32'b1001; cfg_ovl[0] = 1'b1;
    cfg_len[1] = 4; cfg_pat[1] = 32'b1001; cfg_ovl[1] = 1'b0;
    cfg_len[2] = 4; cfg_pat[2] = 32'b0001; cfg_ovl[2] = 1'b1;
    cfg_len[3] = 4; cfg_pat[3] = 32'b1111; cfg_ovl[3] = 1'b1;
    cfg_len[4] = 3; cfg_pat[4] = 32'b101;  cfg_ovl[4] = 1'b0;
    model_reset();
    test_reset();
    test_default();
    test_overlap();
    test_reset_mid();
    test_fill_guard();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
